// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel pixel transmitter and the row-buffer capture logic.
package sobel_pkg;

    localparam int IMG_W_DEF = 32;
    localparam int IMG_H_DEF = 32;
    localparam int PIX_W     = 8;

    // Transmitter FSM encoding; the capture side decodes the same values.
    typedef logic [1:0] tx_state_t;
    localparam tx_state_t ST_IDLE   = 2'd0;
    localparam tx_state_t ST_ACTIVE = 2'd1;
    localparam tx_state_t ST_HBLANK = 2'd2;
    localparam tx_state_t ST_VBLANK = 2'd3;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sobel_timing_gen.sv
// Frame timing for the Sobel pixel transmitter: FSM plus x/y position and
// blanking down-counters.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ST_IDLE   | waiting for start
//   ST_ACTIVE | one pixel addressed per cycle, x = 0..IMG_W-1
//   ST_HBLANK | HBLANK idle cycles after each line
//   ST_VBLANK | VBLANK idle cycles after the last line's HBLANK
module sobel_timing_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int HBLANK = 4,
    parameter int VBLANK = 8,
    localparam int XW    = cnt_w(IMG_W),
    localparam int YW    = cnt_w(IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          continuous,
    output tx_state_t     state,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          line_end,
    output logic          frame_end,
    output logic          line_next,
    output logic          h_first,
    output logic          v_first
);

    localparam int HBW = cnt_w(HBLANK);
    localparam int VBW = cnt_w(VBLANK);

    logic [HBW-1:0] hb_cnt;
    logic [VBW-1:0] vb_cnt;
    logic           x_last;
    logic           y_last;
    logic           hb_tc;
    logic           vb_tc;

    assign x_last    = (x == XW'(IMG_W - 1));
    assign y_last    = (y == YW'(IMG_H - 1));
    assign hb_tc     = (hb_cnt == '0);
    assign vb_tc     = (vb_cnt == '0);
    assign line_end  = (state == ST_ACTIVE) && x_last;
    assign frame_end = (state == ST_VBLANK) && vb_tc;
    assign line_next = (state == ST_HBLANK) && hb_tc && !y_last;
    assign h_first   = (state == ST_HBLANK) && (hb_cnt == HBW'(HBLANK - 1));
    assign v_first   = (state == ST_VBLANK) && (vb_cnt == VBW'(VBLANK - 1));

    // State transitions with position counters and blank down-counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            x      <= '0;
            y      <= '0;
            hb_cnt <= '0;
            vb_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_ACTIVE;
                        x     <= '0;
                        y     <= '0;
                    end
                end
                ST_ACTIVE: begin
                    if (x_last) begin
                        state  <= ST_HBLANK;
                        x      <= '0;
                        hb_cnt <= HBW'(HBLANK - 1);
                    end else begin
                        x <= x + XW'(1);
                    end
                end
                ST_HBLANK: begin
                    if (hb_tc) begin
                        if (!y_last) begin
                            state <= ST_ACTIVE;
                            y     <= y + YW'(1);
                        end else begin
                            state  <= ST_VBLANK;
                            vb_cnt <= VBW'(VBLANK - 1);
                        end
                    end else begin
                        hb_cnt <= hb_cnt - HBW'(1);
                    end
                end
                ST_VBLANK: begin
                    if (vb_tc) begin
                        y     <= '0;
                        state <= continuous ? ST_ACTIVE : ST_IDLE;
                    end else begin
                        vb_cnt <= vb_cnt - VBW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sobel_pixel_tx.sv
// Pixel-stream transmitter: plays a stored frame from a synchronous frame
// memory onto the pixel bus with h_sync/v_sync markers.
// Build option: SOBEL_TX_PATTERN_EN replaces the memory source with an
// internal (x + y) mod 256 test pattern at identical timing.
module sobel_pixel_tx
    import sobel_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int HBLANK = 4,
    parameter int VBLANK = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_data,
    output logic [PIX_W-1:0]  data_out,
    output logic              data_valid,
    output logic              h_sync,
    output logic              v_sync,
    output logic              busy,
    output logic              frame_done
);

    localparam int XW = cnt_w(IMG_W);
    localparam int YW = cnt_w(IMG_H);

    tx_state_t      state;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic           line_end;
    logic           frame_end;
    logic           line_next;
    logic           h_first;
    logic           v_first;
    logic           active;
    logic           frame_start;
    logic           v1, hs1, vs1;
    logic           run_d1, run_d2;
    logic [PIX_W-1:0] pix_src;

    sobel_timing_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .HBLANK (HBLANK),
        .VBLANK (VBLANK)
    ) u_timing (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .continuous (continuous),
        .state      (state),
        .x          (x),
        .y          (y),
        .line_end   (line_end),
        .frame_end  (frame_end),
        .line_next  (line_next),
        .h_first    (h_first),
        .v_first    (v_first)
    );

    assign active      = (state == ST_ACTIVE);
    assign frame_start = ((state == ST_IDLE) && start) || (frame_end && continuous);

    // Linear address: cleared at frame start, +1 per pixel, held across blanking
    // and stepped to the next line's first pixel on the last HBLANK cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr <= '0;
        end else if (frame_start) begin
            mem_addr <= '0;
        end else if ((active && !line_end) || line_next) begin
            mem_addr <= mem_addr + ADDR_W'(1);
        end
    end

`ifdef SOBEL_TX_PATTERN_EN
    logic [PIX_W-1:0] pat_q;
    logic             unused_mem_data;

    assign mem_rd          = 1'b0;
    assign pix_src         = pat_q;
    assign unused_mem_data = ^mem_data;

    // Pattern stands in for the memory read stage so latency is unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q <= '0;
        end else begin
            pat_q <= PIX_W'(x) + PIX_W'(y);
        end
    end
`else
    logic unused_xy;

    assign mem_rd    = active;
    assign pix_src   = mem_data;
    assign unused_xy = ^{x, y};
`endif

    // Stage 1: FSM-derived flags wait alongside the memory read.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1  <= 1'b0;
            hs1 <= 1'b0;
            vs1 <= 1'b0;
        end else begin
            v1  <= active;
            hs1 <= h_first;
            vs1 <= v_first;
        end
    end

    // Stage 2: register pixel and flags onto the output bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            h_sync     <= 1'b0;
            v_sync     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            data_out   <= v1 ? pix_src : '0;
            data_valid <= v1;
            h_sync     <= hs1;
            v_sync     <= vs1;
            frame_done <= vs1;
        end
    end

    // Track non-idle state through both pipeline stages so busy covers the drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_d1 <= 1'b0;
            run_d2 <= 1'b0;
        end else begin
            run_d1 <= (state != ST_IDLE);
            run_d2 <= run_d1;
        end
    end

    assign busy = (state != ST_IDLE) || run_d1 || run_d2;

endmodule

// File: tb/tb_sobel_pixel_tx.sv
// Scoreboard bench for sobel_pixel_tx with a small 4x2 frame.
module tb_sobel_pixel_tx;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int HB   = 2;
    localparam int VB   = 3;
    localparam int AW   = 10;
    localparam int LINE = W + HB;
    localparam int F    = H * LINE + VB;

    typedef struct {
        int         cyc;
        logic [3:0] flags;   // {valid, h_sync, v_sync, frame_done}
        logic [7:0] d;
    } ev_t;

    typedef struct {
        int          cyc;
        logic [AW-1:0] a;
    } rd_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data = 8'h00;
    logic [7:0]    data_out;
    logic          data_valid, h_sync, v_sync, busy, frame_done;
    logic [7:0]    mem [0:(1<<AW)-1];

    ev_t exp_q[$];
    rd_t rd_q[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    int  free_edge = 0;
    int  busy_lo = 0;
    int  busy_hi = 0;
    logic [AW-1:0] last_addr = '0;

    always #5 clk = ~clk;

    sobel_pixel_tx #(
        .IMG_W(W), .IMG_H(H), .HBLANK(HB), .VBLANK(VB), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .data_out(data_out), .data_valid(data_valid), .h_sync(h_sync),
        .v_sync(v_sync), .busy(busy), .frame_done(frame_done)
    );

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(16 + i);
    end

    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem[mem_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] exp_pix(input int xx, input int yy);
`ifdef SOBEL_TX_PATTERN_EN
        return 8'((xx + yy) % 256);
`else
        return 8'(16 + yy * W + xx);
`endif
    endfunction

    // Reference: a frame accepted at edge e produces its whole event list from plain arithmetic.
    task automatic model_frame(input int e);
        for (int yy = 0; yy < H; yy++) begin
            for (int xx = 0; xx < W; xx++) begin
                exp_q.push_back('{e + 2 + yy * LINE + xx, 4'b1000, exp_pix(xx, yy)});
`ifndef SOBEL_TX_PATTERN_EN
                rd_q.push_back('{e + yy * LINE + xx, AW'(yy * W + xx)});
`endif
            end
            exp_q.push_back('{e + 2 + yy * LINE + W, 4'b0100, 8'h00});
        end
        exp_q.push_back('{e + 2 + H * LINE, 4'b0011, 8'h00});
        free_edge = e + F + 1;
        if (e <= busy_hi) busy_hi = e + F + 2;
        else begin
            busy_lo = e;
            busy_hi = e + F + 2;
        end
    endtask

    // Monitor: pop expected stream events and reads whenever the DUT presents them.
    always @(negedge clk) begin
        ev_t        e;
        rd_t        r;
        logic [3:0] fl;
        fl = {data_valid, h_sync, v_sync, frame_done};
        if (fl != 4'b0000) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 64'({32'(cyc), fl, data_out}), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("stream_event", 64'({32'(cyc), fl, data_out}), 64'({32'(e.cyc), e.flags, e.d}));
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            chk("missing_event", 64'({32'(cyc), fl, data_out}), 64'({32'(e.cyc), e.flags, e.d}));
        end
        if (!data_valid) chk("idle_data_zero", 64'(data_out), 64'(0));
        chk("busy", 64'(busy), 64'(cyc >= busy_lo && cyc < busy_hi));
`ifdef SOBEL_TX_PATTERN_EN
        chk("mem_rd_low", 64'(mem_rd), 64'(0));
`else
        if (mem_rd) begin
            if (rd_q.size() == 0) begin
                chk("unexpected_read", 64'({32'(cyc), mem_addr}), 64'(0));
            end else begin
                r = rd_q.pop_front();
                chk("mem_addr", 64'({32'(cyc), mem_addr}), 64'({32'(r.cyc), r.a}));
                last_addr = r.a;
            end
        end else begin
            if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
                r = rd_q.pop_front();
                chk("missing_read", 64'({32'(cyc), mem_addr}), 64'({32'(r.cyc), r.a}));
            end
            chk("mem_addr_hold", 64'(mem_addr), 64'(last_addr));
        end
`endif
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        if (cyc + 1 >= free_edge) model_frame(cyc + 1);
        step();
        start = 1'b0;
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        start = 1'b0;
        continuous = 1'b0;
        exp_q.delete();
        rd_q.delete();
        busy_lo = 0;
        busy_hi = 0;
        free_edge = 0;
        last_addr = '0;
        repeat (n) step();
        chk("reset_outputs",
            64'({data_out, data_valid, h_sync, v_sync, frame_done, busy, mem_rd, mem_addr}), 64'(0));
        rst = 1'b0;
    endtask

    task automatic drain();
        int i;
        i = 0;
        while ((exp_q.size() != 0 || rd_q.size() != 0 || cyc < busy_hi) && i < 300) begin
            step();
            i++;
        end
        chk("drain_pending", 64'(exp_q.size() + rd_q.size()), 64'(0));
    endtask

    initial begin
        int e;
        apply_reset(3);

        // Single frame from idle.
        repeat (2) step();
        pulse_start();
        drain();

        // Continuous: two back-to-back frames, then stop.
        continuous = 1'b1;
        e = cyc + 1;
        pulse_start();
        model_frame(e + F);
        while (cyc < e + F + 1) step();
        continuous = 1'b0;
        drain();

        // Reset at pixel 2 of line 1, then replay.
        e = cyc + 1;
        pulse_start();
        while (cyc < e + LINE + 2) step();
        apply_reset(1);
        step();
        pulse_start();
        drain();

        // Start held through a frame: the next frame follows one idle cycle later.
        start = 1'b1;
        e = cyc + 1;
        if (e >= free_edge) model_frame(e);
        model_frame(e + F + 1);
        while (cyc < e + F + 1) step();
        start = 1'b0;
        drain();

        // Random start pulses, many landing mid-frame.
        for (int k = 0; k < 14; k++) begin
            repeat ($urandom_range(0, 20)) step();
            pulse_start();
        end
        drain();

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
